// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
//   fifo_mode_e  : read-port flavour (registered or first-word-fall-through)
//   fifo_addr_w  : pointer width for a given depth
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
//   master : drives we/din/re/clr_err, observes data, occupancy, flags and errors
//   slave  : the FIFO itself
interface fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  import fifo_pkg::*;

  localparam int unsigned CNT_W = fifo_addr_w(DEPTH) + 1;

  logic             we;
  logic [WIDTH-1:0] din;
  logic             re;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic [CNT_W-1:0] count;
  logic             flagf;
  logic             flage;
  logic             flagaf;
  logic             flagae;
  logic             ovf;
  logic             udf;

  modport master (
    output we, din, re, clr_err,
    input  dout, dvalid, count, flagf, flage, flagaf, flagae, ovf, udf
  );

  modport slave (
    input  we, din, re, clr_err,
    output dout, dvalid, count, flagf, flage, flagaf, flagae, ovf, udf
  );

endinterface

// File: rtl/fifo_ram_2p.sv
// Two-port storage array: one synchronous write port, one read port.
//   clk, rst      : clock; rst only clears the registered read data
//   we/waddr/wdata: write port
//   re/raddr      : read port (re only used by the registered flavour)
//   rdata         : MODE=FIFO_STD -> registered on re, holds otherwise
//                   MODE=FIFO_FWFT -> mem[raddr] combinationally
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter fifo_mode_e  MODE   = FIFO_STD,
  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (MODE == FIFO_FWFT) begin : g_async_rd
    // Read-enable and reset have no effect on a combinational read.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = re ^ rst;
    assign rdata = mem[raddr];
  end else begin : g_sync_rd
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags,
// sticky overflow/underflow and optional first-word-fall-through read.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fifo_if slave (we, din, re, clr_err in; dout, dvalid, count, flagf,
//          flage, flagaf, flagae, ovf, udf out)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic  clk,
  input  logic  rst,
  fifo_if.slave bus
);

  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam fifo_mode_e  MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  // Elaboration-time parameter checks.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (!((AE_THRESH >= 1) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH - 1)))
  begin : g_bad_thresh
    $error("sync_fifo_param: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
  end

  logic [ADDR_W-1:0] wp, rp;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              flagf, flage, flagaf, flagae;
  logic              dvalid, ovf, udf;
  logic              rd_ok, wr_ok;
  logic [WIDTH-1:0]  ram_rdata;

  // Acceptance: a read at full frees the slot the concurrent write needs.
  always_comb begin
    rd_ok     = bus.re & ~flage;
    wr_ok     = bus.we & (~flagf | rd_ok);
    count_nxt = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
  end

  // Pointers, occupancy, flags (pre-decoded from next count) and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      flagf  <= 1'b0;
      flage  <= 1'b1;
      flagaf <= 1'b0;
      flagae <= 1'b1;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + ADDR_W'(1);
      if (rd_ok) rp <= rp + ADDR_W'(1);
      count  <= count_nxt;
      flagf  <= (count_nxt == CNT_W'(DEPTH));
      flage  <= (count_nxt == '0);
      flagaf <= (count_nxt >= CNT_W'(AF_THRESH));
      flagae <= (count_nxt <= CNT_W'(AE_THRESH));
      dvalid <= (MODE == FIFO_FWFT) ? (count_nxt != '0) : rd_ok;
      // A new error takes priority over a same-cycle clear.
      ovf    <= (ovf & ~bus.clr_err) | (bus.we & ~wr_ok);
      udf    <= (udf & ~bus.clr_err) | (bus.re & flage);
    end
  end

  fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~rst),
    .waddr (wp),
    .wdata (bus.din),
    .re    (rd_ok & ~rst),
    .raddr (rp),
    .rdata (ram_rdata)
  );

  // In FWFT mode an empty FIFO presents zero rather than a stale RAM word.
  if (MODE == FIFO_FWFT) begin : g_fwft_out
    assign bus.dout = flage ? '0 : ram_rdata;
  end else begin : g_std_out
    assign bus.dout = ram_rdata;
  end

  assign bus.dvalid = dvalid;
  assign bus.count  = count;
  assign bus.flagf  = flagf;
  assign bus.flage  = flage;
  assign bus.flagaf = flagaf;
  assign bus.flagae = flagae;
  assign bus.ovf    = ovf;
  assign bus.udf    = udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard-mode FIFO against a queue scoreboard, plus
// FWFT and custom-threshold instances checked against fixed expectations.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_if #(.WIDTH(8), .DEPTH(16)) s_if ();
  fifo_if #(.WIDTH(8), .DEPTH(16)) f_if ();
  fifo_if #(.WIDTH(8), .DEPTH(16)) t_if ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(16)) u_std (
    .clk (clk), .rst (rst), .bus (s_if.slave));
  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk (clk), .rst (rst), .bus (f_if.slave));
  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) u_thr (
    .clk (clk), .rst (rst), .bus (t_if.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Standard-mode reference model.
  logic [7:0] sb_q[$];
  int         m_cnt  = 0;
  bit         m_ovf  = 0;
  bit         m_udf  = 0;
  logic [7:0] m_dout = 8'h00;

  task automatic check_std(input bit exp_dvalid);
    check("std_count",  32'(s_if.count),  32'(m_cnt));
    check("std_dvalid", 32'(s_if.dvalid), 32'(exp_dvalid));
    check("std_dout",   32'(s_if.dout),   32'(m_dout));
    check("std_flagf",  32'(s_if.flagf),  32'(m_cnt == 16));
    check("std_flage",  32'(s_if.flage),  32'(m_cnt == 0));
    check("std_flagaf", 32'(s_if.flagaf), 32'(m_cnt >= 15));
    check("std_flagae", 32'(s_if.flagae), 32'(m_cnt <= 1));
    check("std_ovf",    32'(s_if.ovf),    32'(m_ovf));
    check("std_udf",    32'(s_if.udf),    32'(m_udf));
  endtask

  // One clock of stimulus on the standard FIFO, then compare after the edge.
  task automatic std_step(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit rok, wok;
    rok = r && (m_cnt != 0);
    wok = w && ((m_cnt != 16) || rok);
    if (rok) m_dout = sb_q.pop_front();
    if (wok) sb_q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wok);
    m_udf = (m_udf && !c) || (r && (m_cnt == 0));
    m_cnt = m_cnt + int'(wok) - int'(rok);
    s_if.we = w; s_if.din = d; s_if.re = r; s_if.clr_err = c;
    @(posedge clk); #1;
    s_if.we = 1'b0; s_if.re = 1'b0; s_if.clr_err = 1'b0;
    check_std(rok);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    m_cnt = 0; m_ovf = 0; m_udf = 0; m_dout = 8'h00;
  endtask

  initial begin
    s_if.we = 0; s_if.din = 0; s_if.re = 0; s_if.clr_err = 0;
    f_if.we = 0; f_if.din = 0; f_if.re = 0; f_if.clr_err = 0;
    t_if.we = 0; t_if.din = 0; t_if.re = 0; t_if.clr_err = 0;
    @(posedge clk);
    do_reset();
    check_std(1'b0);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) std_step(1'b1, 8'(i), 1'b0, 1'b0);
    std_step(1'b1, 8'hEE, 1'b0, 1'b0);

    // Drain in order, then underflow; dout holds the last word.
    for (int i = 0; i < 16; i++) std_step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_last", 32'(s_if.dout), 32'h0F);
    std_step(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear errors, refill, simultaneous write+read at full.
    std_step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) std_step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    std_step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) std_step(1'b0, 8'h00, 1'b1, 1'b0);
    check("aa_last", 32'(s_if.dout), 32'hAA);
    // Simultaneous write+read at empty.
    std_step(1'b1, 8'h77, 1'b1, 1'b0);
    std_step(1'b0, 8'h00, 1'b1, 1'b1);

    // Random interleaving of 40 words across pointer wrap.
    begin
      int written = 0;
      for (int cyc = 0; cyc < 400 && (written < 40 || m_cnt != 0); cyc++) begin
        bit r, w;
        r = ($urandom_range(0, 1) == 1) && (m_cnt > 0);
        w = ($urandom_range(0, 2) != 0) && (written < 40) && ((m_cnt < 16) || r);
        std_step(w, 8'($urandom), r, 1'b0);
        if (w) written++;
      end
      check("rand_written", 32'(written), 32'd40);
      check("rand_drained", 32'(m_cnt), 32'd0);
    end

    // Reset mid-operation at count=9 with overflow pending.
    for (int i = 0; i < 17; i++) std_step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) std_step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_count", 32'(s_if.count), 32'd9);
    check("pre_rst_ovf",   32'(s_if.ovf),   32'd1);
    do_reset();
    check("rst_count", 32'(s_if.count), 32'd0);
    check("rst_flage", 32'(s_if.flage), 32'd1);
    check("rst_ovf",   32'(s_if.ovf),   32'd0);
    std_step(1'b1, 8'h3C, 1'b0, 1'b0);
    std_step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_dout", 32'(s_if.dout), 32'h3C);

    // FWFT: word appears without a read request.
    check("fwft_rst_flage",  32'(f_if.flage),  32'd1);
    check("fwft_rst_dvalid", 32'(f_if.dvalid), 32'd0);
    f_if.we = 1'b1; f_if.din = 8'hA5;
    @(posedge clk); #1;
    f_if.we = 1'b0;
    check("fwft_dout",   32'(f_if.dout),   32'hA5);
    check("fwft_dvalid", 32'(f_if.dvalid), 32'd1);
    f_if.re = 1'b1;
    @(posedge clk); #1;
    f_if.re = 1'b0;
    check("fwft_pop_flage",  32'(f_if.flage),  32'd1);
    check("fwft_pop_dvalid", 32'(f_if.dvalid), 32'd0);
    f_if.we = 1'b1; f_if.din = 8'h11;
    @(posedge clk); #1;
    f_if.din = 8'h22;
    @(posedge clk); #1;
    f_if.we = 1'b0;
    check("fwft_head1", 32'(f_if.dout), 32'h11);
    f_if.re = 1'b1;
    @(posedge clk); #1;
    f_if.re = 1'b0;
    check("fwft_head2", 32'(f_if.dout), 32'h22);
    check("fwft_count", 32'(f_if.count), 32'd1);

    // Custom thresholds: AF=12, AE=4.
    for (int i = 1; i <= 12; i++) begin
      t_if.we = 1'b1; t_if.din = 8'(i);
      @(posedge clk); #1;
      t_if.we = 1'b0;
      check("thr_count_up",  32'(t_if.count),  32'(i));
      check("thr_flagaf_up", 32'(t_if.flagaf), 32'(i >= 12));
      check("thr_flagae_up", 32'(t_if.flagae), 32'(i <= 4));
    end
    for (int i = 11; i >= 0; i--) begin
      t_if.re = 1'b1;
      @(posedge clk); #1;
      t_if.re = 1'b0;
      check("thr_count_dn",  32'(t_if.count),  32'(i));
      check("thr_flagaf_dn", 32'(t_if.flagaf), 32'(i >= 12));
      check("thr_flagae_dn", 32'(t_if.flagae), 32'(i <= 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
